snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, giving the maximum number of segments.
REQ-002 The block SHALL have parameter POS_W, default 10, giving the width of a cell index.
REQ-003 The block SHALL have parameter WIDTH, default 32, giving the grid columns.
REQ-004 The block SHALL have parameter HEIGHT, default 24, giving the grid rows.
REQ-005 The block SHALL have parameter LEN_W, default 5, giving the width of the length counter, which holds 0..MAX_LEN.
REQ-006 The block SHALL have parameter INIT_LEN, default 3, giving the length after reset; valid range 1..MAX_LEN.
REQ-007 The block SHALL have parameter INIT_POS, default 400, giving the head cell after reset; INIT_POS%WIDTH >= INIT_LEN-1.
REQ-008 The block SHALL have these ports, one per line:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  single-cycle move strobe.
- dir  in  2  requested direction: 00 left, 01 right, 10 up, 11 down.
- grow  in  1  single-cycle growth request.
- body_pos  out  MAX_LEN*POS_W  segment i at bits [i*POS_W +: POS_W]; segment 0 is the head.
- len  out  LEN_W  current segment count.
- cur_dir  out  2  direction actually applied.
- dead  out  1  game-over flag.
- moved  out  1  one-cycle pulse after each accepted move.

Function
REQ-009 The FSM SHALL have two states, RUN and DEAD; reset enters RUN; a death event moves RUN to DEAD; only rst leaves DEAD.
REQ-010 In DEAD, step and grow SHALL be ignored, and body_pos, len and cur_dir SHALL hold their values.
REQ-011 A grow pulse SHALL set an internal grow_pend flag; grow_pend SHALL clear on the next accepted move.
REQ-012 On step in RUN, dir SHALL be adopted unless it is the exact reverse of cur_dir (00<->01, 10<->11); a reverse request SHALL keep cur_dir.
REQ-013 The candidate head SHALL be head-1, head+1, head-WIDTH or head+WIDTH for left, right, up and down respectively.
REQ-014 A wall hit SHALL be detected when:
- moving left with head%WIDTH==0, or
- moving right with head%WIDTH==WIDTH-1, or
- moving up with head/WIDTH==0, or
- moving down with head/WIDTH==HEIGHT-1.
REQ-015 A self-collision SHALL be detected when the candidate equals segment i for any 1 <= i <= len-1, excluding i=len-1 when grow_pend=0, because the tail vacates that cell.
REQ-016 On a wall hit or self-collision, the block SHALL enter DEAD on the next clk edge, set dead=1, leave body_pos unchanged and not pulse moved.
REQ-017 Otherwise, on the next clk edge, segment i SHALL take segment i-1 for i>=1, segment 0 SHALL take the candidate, and moved=1 for exactly one cycle.
REQ-018 A move with grow_pend=1 SHALL increment len, saturating at MAX_LEN; at saturation the move SHALL proceed without growth.
REQ-019 A grow pulse coinciding with step SHALL be applied to that same move.
REQ-020 Outputs SHALL be registered, with a latency of 1 clk from step.
REQ-021 Segments at index >= len SHALL hold the shifted-out values; only segments below len are meaningful.

Reset
REQ-022 While rst=1, the block SHALL asynchronously set:
- state=RUN, dead=0, moved=0, grow_pend=0
- len=INIT_LEN, cur_dir=01
- segment i = INIT_POS-i for i < INIT_LEN
- segment i = INIT_POS-(INIT_LEN-1) for i >= INIT_LEN
REQ-023 Assertion of rst mid-move SHALL discard the pending move and grow request.

Configuration
REQ-024 With macro SNAKE_WRAP_EN defined, wall hits SHALL NOT cause death; the head SHALL wrap as follows:
- left from column 0 to column WIDTH-1 of the same row
- right from column WIDTH-1 to column 0
- up from row 0 to row HEIGHT-1
- down from row HEIGHT-1 to row 0
REQ-025 Without SNAKE_WRAP_EN, wall hits SHALL cause death per REQ-016.

Verification
REQ-026 Reset, then one step with dir=01 -> head=401, segment1=400, segment2=399, len=3, moved pulse.
REQ-027 cur_dir=01, step with dir=00 -> cur_dir stays 01, head advances right by one.
REQ-028 grow pulse, then step -> len=4 and the tail segment is retained; grow held across MAX_LEN moves -> len saturates at 16.
REQ-029 Head at column 31 moving right, without SNAKE_WRAP_EN -> dead=1 and body frozen; with SNAKE_WRAP_EN -> head moves to column 0 of the same row, dead=0.
REQ-030 Build len=5, then issue up, left, down -> head hits segment 3 -> dead=1; tail-chasing move with grow_pend=0 -> no death.
REQ-031 Assert rst while dead=1 -> all reset values restored and moves resume.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: snake game datapath and RUN/DEAD controller.
// Each step moves the head one cell in the applied direction. The body shifts
// behind the head. A pending grow request lengthens the snake on the next move.
// A wall hit or self-collision freezes the snake until rst.
// Optional feature: define SNAKE_WRAP_EN to wrap the head around the grid
// edges instead of dying on a wall hit.
module snake_engine #(
  parameter int MAX_LEN  = 16,
  parameter int POS_W    = 10,
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 24,
  parameter int LEN_W    = 5,
  parameter int INIT_LEN = 3,
  parameter int INIT_POS = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic [1:0]               dir,
  input  logic                     grow,
  output logic [MAX_LEN*POS_W-1:0] body_pos,
  output logic [LEN_W-1:0]         len,
  output logic [1:0]               cur_dir,
  output logic                     dead,
  output logic                     moved
);

  typedef enum logic {RUN, DEAD} state_t;

  localparam logic [POS_W-1:0] W_P = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] H_P = POS_W'(HEIGHT);
`ifdef SNAKE_WRAP_EN
  localparam logic [POS_W-1:0] WRAP_V = POS_W'(WIDTH * (HEIGHT - 1));
`endif

  state_t           state;
  logic             grow_pend;
  logic [POS_W-1:0] seg [MAX_LEN];

  logic [1:0]       new_dir;
  logic [POS_W-1:0] head, col, row, cand;
  logic             wall, self_hit, grow_eff, death;

  // Pack the segment registers onto the flat output bus, head in the low bits.
  always_comb begin
    body_pos = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      body_pos[i*POS_W +: POS_W] = seg[i];
    end
  end

  // Direction filter, candidate head, wall and self-collision detection.
  always_comb begin
    // A reverse request differs from cur_dir only in bit 0.
    new_dir  = (dir[1] == cur_dir[1] && dir[0] != cur_dir[0]) ? cur_dir : dir;
    head     = seg[0];
    col      = head % W_P;
    row      = head / W_P;
    grow_eff = grow_pend | grow;
    wall     = 1'b0;
    cand     = head;
    case (new_dir)
      2'b00: begin
        wall = (col == '0);
        cand = head - POS_W'(1);
`ifdef SNAKE_WRAP_EN
        if (wall) cand = head + (W_P - POS_W'(1));
`endif
      end
      2'b01: begin
        wall = (col == W_P - POS_W'(1));
        cand = head + POS_W'(1);
`ifdef SNAKE_WRAP_EN
        if (wall) cand = head - (W_P - POS_W'(1));
`endif
      end
      2'b10: begin
        wall = (row == '0);
        cand = head - W_P;
`ifdef SNAKE_WRAP_EN
        if (wall) cand = head + WRAP_V;
`endif
      end
      default: begin
        wall = (row == H_P - POS_W'(1));
        cand = head + W_P;
`ifdef SNAKE_WRAP_EN
        if (wall) cand = head - WRAP_V;
`endif
      end
    endcase
    // The tail cell is free unless this move grows the snake.
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len && cand == seg[i] &&
          !(LEN_W'(i) == len - LEN_W'(1) && !grow_eff)) begin
        self_hit = 1'b1;
      end
    end
`ifdef SNAKE_WRAP_EN
    death = self_hit;
`else
    death = wall | self_hit;
`endif
  end

  // RUN/DEAD controller with registered body, length, direction and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      dead      <= 1'b0;
      moved     <= 1'b0;
      grow_pend <= 1'b0;
      len       <= LEN_W'(INIT_LEN);
      cur_dir   <= 2'b01;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg[i] <= (i < INIT_LEN) ? POS_W'(INIT_POS - i) : POS_W'(INIT_POS - (INIT_LEN - 1));
      end
    end else begin
      moved <= 1'b0;
      case (state)
        RUN: begin
          if (step) begin
            if (death) begin
              state <= DEAD;
              dead  <= 1'b1;
            end else begin
              cur_dir   <= new_dir;
              seg[0]    <= cand;
              for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
              moved     <= 1'b1;
              grow_pend <= 1'b0;
              if (grow_eff && len < LEN_W'(MAX_LEN)) len <= len + LEN_W'(1);
            end
          end else if (grow) begin
            grow_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed testbench for snake_engine (default parameters).
module tb_snake_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         step = 1'b0;
  logic [1:0]   dir = 2'b01;
  logic         grow = 1'b0;
  logic [159:0] body_pos;
  logic [4:0]   len;
  logic [1:0]   cur_dir;
  logic         dead;
  logic         moved;

  int checks = 0;
  int errors = 0;

  snake_engine dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
    .body_pos(body_pos), .len(len), .cur_dir(cur_dir), .dead(dead), .moved(moved)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] seg(input int i);
    return body_pos[i*10 +: 10];
  endfunction

  task automatic do_step(input logic [1:0] d, input logic g);
    @(negedge clk);
    step = 1'b1; dir = d; grow = g;
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
  endtask

  task automatic pulse_grow();
    @(negedge clk);
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL reset_len got %0d want 3", len); end
    checks++; if (cur_dir !== 2'b01) begin errors++; $display("FAIL reset_dir got %0d want 1", cur_dir); end
    checks++; if (dead !== 1'b0 || moved !== 1'b0) begin errors++; $display("FAIL reset_flags got dead=%0d moved=%0d want 0 0", dead, moved); end
    checks++; if (seg(0) !== 10'd400 || seg(1) !== 10'd399 || seg(2) !== 10'd398) begin
      errors++; $display("FAIL reset_body got %0d %0d %0d want 400 399 398", seg(0), seg(1), seg(2)); end
    checks++; if (seg(3) !== 10'd398 || seg(15) !== 10'd398) begin
      errors++; $display("FAIL reset_fill got %0d %0d want 398 398", seg(3), seg(15)); end
  endtask

  task automatic test_move();
    do_step(2'b01, 1'b0);
    checks++; if (seg(0) !== 10'd401 || seg(1) !== 10'd400 || seg(2) !== 10'd399) begin
      errors++; $display("FAIL move_body got %0d %0d %0d want 401 400 399", seg(0), seg(1), seg(2)); end
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL move_len got %0d want 3", len); end
    checks++; if (moved !== 1'b1) begin errors++; $display("FAIL move_pulse got %0d want 1", moved); end
    @(negedge clk);
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL move_pulse_end got %0d want 0", moved); end
  endtask

  task automatic test_reverse();
    do_step(2'b00, 1'b0);
    checks++; if (cur_dir !== 2'b01) begin errors++; $display("FAIL rev_dir got %0d want 1", cur_dir); end
    checks++; if (seg(0) !== 10'd402) begin errors++; $display("FAIL rev_head got %0d want 402", seg(0)); end
  endtask

  task automatic test_grow();
    pulse_grow();
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL grow_wait_len got %0d want 3", len); end
    do_step(2'b01, 1'b0);
    checks++; if (len !== 5'd4) begin errors++; $display("FAIL grow_len got %0d want 4", len); end
    checks++; if (seg(0) !== 10'd403 || seg(3) !== 10'd400) begin
      errors++; $display("FAIL grow_body got head=%0d tail=%0d want 403 400", seg(0), seg(3)); end
    do_step(2'b01, 1'b0);
    checks++; if (len !== 5'd4) begin errors++; $display("FAIL grow_clear got %0d want 4", len); end
    do_step(2'b01, 1'b1);
    checks++; if (len !== 5'd5) begin errors++; $display("FAIL grow_same got %0d want 5", len); end
  endtask

  task automatic test_saturate_and_wall();
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      do_step(2'b01, 1'b1);
      if (k == 13 || k == 14) begin
        checks++; if (len !== 5'd16) begin errors++; $display("FAIL sat_len move %0d got %0d want 16", k, len); end
      end
    end
    checks++; if (seg(0) !== 10'd414 || moved !== 1'b1) begin
      errors++; $display("FAIL sat_move got head=%0d moved=%0d want 414 1", seg(0), moved); end
    do_step(2'b01, 1'b0);
    checks++; if (seg(0) !== 10'd415 || seg(15) !== 10'd400) begin
      errors++; $display("FAIL edge_body got %0d %0d want 415 400", seg(0), seg(15)); end
    do_step(2'b01, 1'b0);
`ifdef SNAKE_WRAP_EN
    checks++; if (seg(0) !== 10'd384 || dead !== 1'b0 || moved !== 1'b1) begin
      errors++; $display("FAIL wrap got head=%0d dead=%0d moved=%0d want 384 0 1", seg(0), dead, moved); end
`else
    checks++; if (dead !== 1'b1 || seg(0) !== 10'd415 || seg(1) !== 10'd414 || moved !== 1'b0) begin
      errors++; $display("FAIL wall got dead=%0d head=%0d s1=%0d moved=%0d want 1 415 414 0", dead, seg(0), seg(1), moved); end
    do_step(2'b10, 1'b1);
    checks++; if (dead !== 1'b1 || seg(0) !== 10'd415 || len !== 5'd16 || cur_dir !== 2'b01 || moved !== 1'b0) begin
      errors++; $display("FAIL dead_hold got dead=%0d head=%0d len=%0d dir=%0d moved=%0d", dead, seg(0), len, cur_dir, moved); end
`endif
  endtask

  task automatic test_self_collision();
    apply_reset();
    do_step(2'b01, 1'b1);
    do_step(2'b01, 1'b1);
    checks++; if (len !== 5'd5 || seg(0) !== 10'd402) begin
      errors++; $display("FAIL col_build got len=%0d head=%0d want 5 402", len, seg(0)); end
    do_step(2'b10, 1'b0);
    do_step(2'b00, 1'b0);
    checks++; if (seg(0) !== 10'd369 || seg(3) !== 10'd401) begin
      errors++; $display("FAIL col_path got head=%0d s3=%0d want 369 401", seg(0), seg(3)); end
    do_step(2'b11, 1'b0);
    checks++; if (dead !== 1'b1 || seg(0) !== 10'd369 || moved !== 1'b0 || len !== 5'd5) begin
      errors++; $display("FAIL col_dead got dead=%0d head=%0d moved=%0d len=%0d want 1 369 0 5", dead, seg(0), moved, len); end
  endtask

  task automatic test_reset_recover();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dead !== 1'b0 || len !== 5'd3 || cur_dir !== 2'b01 || seg(0) !== 10'd400 || seg(2) !== 10'd398) begin
      errors++; $display("FAIL rst_dead got dead=%0d len=%0d dir=%0d head=%0d s2=%0d", dead, len, cur_dir, seg(0), seg(2)); end
    @(negedge clk);
    rst = 1'b0;
    pulse_grow();
    @(negedge clk);
    step = 1'b1; dir = 2'b01; grow = 1'b1;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step = 1'b0; grow = 1'b0;
    do_step(2'b01, 1'b0);
    checks++; if (len !== 5'd3 || seg(0) !== 10'd401 || dead !== 1'b0) begin
      errors++; $display("FAIL rst_midmove got len=%0d head=%0d dead=%0d want 3 401 0", len, seg(0), dead); end
  endtask

  task automatic test_tail_chase();
    apply_reset();
    do_step(2'b01, 1'b1);
    do_step(2'b10, 1'b0);
    do_step(2'b00, 1'b0);
    checks++; if (seg(0) !== 10'd368 || seg(3) !== 10'd400 || len !== 5'd4) begin
      errors++; $display("FAIL chase_path got head=%0d s3=%0d len=%0d want 368 400 4", seg(0), seg(3), len); end
    do_step(2'b11, 1'b0);
    checks++; if (dead !== 1'b0 || seg(0) !== 10'd400 || seg(3) !== 10'd401 || moved !== 1'b1) begin
      errors++; $display("FAIL chase got dead=%0d head=%0d s3=%0d moved=%0d want 0 400 401 1", dead, seg(0), seg(3), moved); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_reverse();
    test_grow();
    test_saturate_and_wall();
    test_self_collision();
    test_reset_recover();
    test_tail_chase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
